// File: rtl/pipe_hazard_sb_pkg.sv
// Shared types and latency derivation for the scoreboard hazard controller.
// Honours PIPE_FWD_EN: when undefined, writer latencies grow by two cycles.
package pipe_pkg;

  typedef enum logic [1:0] {
    REG = 2'b00,
    EXE = 2'b01,
    MEM = 2'b10,
    WB  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    MUL_IDLE,
    MUL_BUSY
  } mul_state_t;

  localparam int unsigned RW_MAX = 8;

  typedef struct packed {
    logic              valid;
    logic [RW_MAX-1:0] wn;
  } stage_tag_t;

`ifdef PIPE_FWD_EN
  localparam int unsigned NOFWD_EXTRA = 0;
`else
  // Without bypass paths a reader must wait until after the WB write.
  localparam int unsigned NOFWD_EXTRA = 2;
`endif

  // Counter preset for a writer whose forwarded latency is d_fwd.
  function automatic int unsigned set_count(input int unsigned d_fwd);
    return d_fwd + NOFWD_EXTRA - 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_sb_if.sv
// ID-stage handshake between the decoder (master) and the hazard controller (slave).
interface pipe_hazard_sb_if import pipe_pkg::*; #(
  parameter int unsigned RW = 5
) ();
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic          id_wreg;
  logic [RW-1:0] id_wn;
  logic          id_is_load;
  logic          id_is_mul;
  logic          btaken;
  logic          stall;
  logic          id_issue;
  logic          id_kill;
  fwd_sel_t      fwd_a;
  fwd_sel_t      fwd_b;
  logic          mul_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_wn,
           id_is_load, id_is_mul, btaken,
    input  stall, id_issue, id_kill, fwd_a, fwd_b, mul_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_wn,
           id_is_load, id_is_mul, btaken,
    output stall, id_issue, id_kill, fwd_a, fwd_b, mul_busy
  );
endinterface

// File: rtl/pipe_mul_occ.sv
// Multiplier occupancy FSM: holds EXE for MUL_LAT-1 cycles after a MUL issues.
module pipe_mul_occ import pipe_pkg::*; #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CW      = 3
) (
  input  logic clk,
  input  logic clrn,
  input  logic start,
  output logic mul_busy,
  output logic hold
);

  mul_state_t    state;
  logic [CW-1:0] mcnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= MUL_IDLE;
      mcnt     <= '0;
      mul_busy <= 1'b0;
      hold     <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start && MUL_LAT > 1) begin
            state    <= MUL_BUSY;
            mcnt     <= CW'(MUL_LAT - 1);
            mul_busy <= 1'b1;
            hold     <= 1'b1;
          end
        end
        MUL_BUSY: begin
          if (mcnt == CW'(1)) begin
            state    <= MUL_IDLE;
            mcnt     <= '0;
            mul_busy <= 1'b0;
            hold     <= 1'b0;
          end else begin
            mcnt <= mcnt - CW'(1);
          end
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_sb.sv
// Scoreboard hazard controller: per-register pending counters, mul occupancy, forwarding selects.
// Define PIPE_FWD_EN to enable EXE/MEM/WB forwarding; otherwise fwd_a/fwd_b are tied to REG.
module pipe_hazard_sb import pipe_pkg::*; #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned RW       = $clog2(NREG),
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned CW       = 3
) (
  input  logic            clk,
  input  logic            clrn,
  pipe_hazard_sb_if.slave hz
);

  localparam logic [CW-1:0] SET_ALU  = CW'(set_count(1));
  localparam logic [CW-1:0] SET_LOAD = CW'(set_count(1 + LOAD_LAT));
  localparam logic [CW-1:0] SET_MUL  = CW'(set_count(MUL_LAT));

  logic [CW-1:0] cnt [NREG];
  logic          src_hz;
  logic          hold;
  logic          set_en;
  logic          mul_start;
  logic [CW-1:0] set_val;

  always_comb begin
    src_hz = (hz.id_rs_used && hz.id_rs != '0 && cnt[hz.id_rs] != '0) ||
             (hz.id_rt_used && hz.id_rt != '0 && cnt[hz.id_rt] != '0);
    hz.id_kill  = hz.id_valid & hz.btaken;
    hz.stall    = hz.id_valid & ~hz.btaken & (src_hz | hold);
    hz.id_issue = hz.id_valid & ~hz.btaken & ~hz.stall;
    set_en      = hz.id_issue & hz.id_wreg & (hz.id_wn != '0);
    mul_start   = hz.id_issue & hz.id_is_mul;
    set_val     = hz.id_is_mul ? SET_MUL : (hz.id_is_load ? SET_LOAD : SET_ALU);
  end

  // The issue-time preset is the later NBA, so it overrides the decrement.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
      end
      if (set_en) cnt[hz.id_wn] <= set_val;
    end
  end

  pipe_mul_occ #(
    .MUL_LAT (MUL_LAT),
    .CW      (CW)
  ) u_mul_occ (
    .clk      (clk),
    .clrn     (clrn),
    .start    (mul_start),
    .mul_busy (hz.mul_busy),
    .hold     (hold)
  );

`ifdef PIPE_FWD_EN
  stage_tag_t exe_tag, mem_tag, wb_tag, new_tag;

  always_comb begin
    new_tag.valid = set_en;
    new_tag.wn    = RW_MAX'(hz.id_wn);
  end

  // While the multiplier holds EXE, MEM takes a bubble and WB keeps draining.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      exe_tag <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else if (hold) begin
      mem_tag <= '0;
      wb_tag  <= mem_tag;
    end else begin
      exe_tag <= new_tag;
      mem_tag <= exe_tag;
      wb_tag  <= mem_tag;
    end
  end

  function automatic fwd_sel_t pick(input logic [RW-1:0] src, input stage_tag_t e,
                                    input stage_tag_t m, input stage_tag_t w);
    if (src == '0)                              return REG;
    else if (e.valid && e.wn == RW_MAX'(src))   return EXE;
    else if (m.valid && m.wn == RW_MAX'(src))   return MEM;
    else if (w.valid && w.wn == RW_MAX'(src))   return WB;
    else                                        return REG;
  endfunction

  always_comb begin
    hz.fwd_a = pick(hz.id_rs, exe_tag, mem_tag, wb_tag);
    hz.fwd_b = pick(hz.id_rt, exe_tag, mem_tag, wb_tag);
  end
`else
  always_comb begin
    hz.fwd_a = REG;
    hz.fwd_b = REG;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Self-checking bench for pipe_hazard_sb: directed scenarios plus random traffic vs a timeline model.
module tb_pipe_hazard_sb;
  import pipe_pkg::*;

  localparam int NREG = 32, RW = 5, LOAD_LAT = 1, MUL_LAT = 3, CW = 3;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  pipe_hazard_sb_if #(.RW(RW)) hz ();

  pipe_hazard_sb #(
    .NREG(NREG), .RW(RW), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CW(CW)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .hz   (hz)
  );

  int checks = 0;
  int errors = 0;

  // Model: absolute cycle at which each register becomes readable, and the
  // list of in-flight writers with the cycle they issued and their EXE residency.
  typedef struct { int wn; int t; int len; } wr_t;
  int   now = 0;
  int   ready [NREG];
  int   mul_free = 0;
  wr_t  inflight [$];
  logic e_stall, e_issue, e_kill, e_busy;
  logic [1:0] e_fa, e_fb;
  logic [7:0] expv, obs;

  function automatic int d_of(input logic ld, input logic mul);
    int d;
    d = mul ? MUL_LAT : (ld ? 1 + LOAD_LAT : 1);
    return d + (FWD ? 0 : 2);
  endfunction

  function automatic logic [1:0] model_fwd(input int src);
    int best = 0;
    if (!FWD || src == 0) return 2'b00;
    foreach (inflight[i]) begin
      int st = 0;
      int t  = inflight[i].t;
      int ln = inflight[i].len;
      if (inflight[i].wn == src) begin
        if (now >= t + 1 && now <= t + ln) st = 1;
        else if (now == t + ln + 1)        st = 2;
        else if (now == t + ln + 2)        st = 3;
        if (st != 0 && (best == 0 || st < best)) best = st;
      end
    end
    return 2'(best);
  endfunction

  function automatic void model_eval();
    logic h_rs, h_rt;
    e_busy  = now < mul_free;
    h_rs    = hz.id_rs_used && hz.id_rs != 0 && now < ready[hz.id_rs];
    h_rt    = hz.id_rt_used && hz.id_rt != 0 && now < ready[hz.id_rt];
    e_kill  = hz.id_valid & hz.btaken;
    e_stall = hz.id_valid & ~hz.btaken & (h_rs | h_rt | e_busy);
    e_issue = hz.id_valid & ~hz.btaken & ~e_stall;
    e_fa    = model_fwd(int'(hz.id_rs));
    e_fb    = model_fwd(int'(hz.id_rt));
    expv    = {e_stall, e_issue, e_kill, e_busy, e_fa, e_fb};
  endfunction

  function automatic void model_update();
    if (e_issue) begin
      if (hz.id_is_mul) mul_free = now + MUL_LAT;
      if (hz.id_wreg && hz.id_wn != 0) begin
        ready[hz.id_wn] = now + d_of(hz.id_is_load, hz.id_is_mul);
        inflight.push_back('{int'(hz.id_wn), now, hz.id_is_mul ? MUL_LAT : 1});
      end
    end
    now++;
    while (inflight.size() > 0 && inflight[0].t + inflight[0].len + 2 < now)
      void'(inflight.pop_front());
  endfunction

  function automatic void model_reset();
    foreach (ready[i]) ready[i] = 0;
    mul_free = 0;
    inflight.delete();
  endfunction

  function automatic logic [7:0] sample();
    return {hz.stall, hz.id_issue, hz.id_kill, hz.mul_busy, 2'(hz.fwd_a), 2'(hz.fwd_b)};
  endfunction

  task automatic set_in(input logic v, input int rs, input int rt, input logic rsu,
                        input logic rtu, input logic wreg, input int wn,
                        input logic ld, input logic mul, input logic bt);
    hz.id_valid = v;   hz.id_rs = RW'(rs);  hz.id_rt = RW'(rt);
    hz.id_rs_used = rsu; hz.id_rt_used = rtu; hz.id_wreg = wreg;
    hz.id_wn = RW'(wn); hz.id_is_load = ld; hz.id_is_mul = mul; hz.btaken = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_eval();
    model_update();
    #2;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    set_in(1, 5, 6, 1, 1, 1, 5, 0, 0, 0);
    #3;
    obs = sample(); checks++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL reset_issue: got %b want %b", obs, 8'b0100_0000); end
    hz.btaken = 1'b1;
    #1;
    obs = sample(); checks++;
    if (obs !== 8'b0010_0000) begin errors++; $display("FAIL reset_kill: got %b want %b", obs, 8'b0010_0000); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_alu_fwd();
    int stalls = 0;
    set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL alu_writer: got %b want %b", obs, expv); end
    tick();
    set_in(1, 5, 0, 1, 0, 1, 6, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL alu_dep: got %b want %b", obs, expv); end
    checks++;
    if (hz.stall !== !FWD || hz.fwd_a !== (FWD ? 2'b01 : 2'b00)) begin
      errors++; $display("FAIL alu_dep_sel: got stall=%b fwd_a=%b want stall=%b fwd_a=%b",
                         hz.stall, hz.fwd_a, !FWD, FWD ? 2'b01 : 2'b00);
    end
    for (int k = 0; k < 8 && hz.stall === 1'b1; k++) begin
      tick(); stalls++;
      @(negedge clk); model_eval(); obs = sample(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL alu_dep_wait: got %b want %b", obs, expv); end
    end
    checks++;
    if (stalls != (FWD ? 0 : 2) || hz.id_issue !== 1'b1) begin
      errors++; $display("FAIL alu_stalls: got %0d issue=%b want %0d issue=1", stalls, hz.id_issue, FWD ? 0 : 2);
    end
    tick();
    set_in(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL alu_later: got %b want %b", obs, expv); end
    checks++;
    if (hz.fwd_a !== (FWD ? 2'b10 : 2'b00)) begin
      errors++; $display("FAIL alu_mem_sel: got %b want %b", hz.fwd_a, FWD ? 2'b10 : 2'b00);
    end
    tick();
  endtask

  task automatic test_load_use();
    int stalls = 0;
    idle(5);
    set_in(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL load_issue: got %b want %b", obs, expv); end
    tick();
    set_in(1, 1, 3, 0, 1, 1, 11, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL load_dep: got %b want %b", obs, expv); end
    for (int k = 0; k < 8 && hz.stall === 1'b1; k++) begin
      tick(); stalls++;
      @(negedge clk); model_eval(); obs = sample(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL load_wait: got %b want %b", obs, expv); end
    end
    checks++;
    if (stalls != (FWD ? 1 : 3) || hz.fwd_b !== (FWD ? 2'b10 : 2'b00)) begin
      errors++; $display("FAIL load_use: got stalls=%0d fwd_b=%b want stalls=%0d fwd_b=%b",
                         stalls, hz.fwd_b, FWD ? 1 : 3, FWD ? 2'b10 : 2'b00);
    end
    tick();
  endtask

  task automatic test_mul_occ();
    int stalls = 0, busy = 0;
    idle(6);
    set_in(1, 0, 0, 0, 0, 1, 7, 0, 1, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL mul_issue: got %b want %b", obs, expv); end
    tick();
    set_in(1, 12, 13, 1, 1, 1, 14, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL mul_indep: got %b want %b", obs, expv); end
    for (int k = 0; k < 8 && hz.stall === 1'b1; k++) begin
      if (hz.mul_busy === 1'b1) busy++;
      tick(); stalls++;
      @(negedge clk); model_eval(); obs = sample(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL mul_wait: got %b want %b", obs, expv); end
    end
    checks++;
    if (stalls != MUL_LAT - 1 || busy != MUL_LAT - 1) begin
      errors++; $display("FAIL mul_occ: got stalls=%0d busy=%0d want %0d", stalls, busy, MUL_LAT - 1);
    end
    tick();
    set_in(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); model_eval(); obs = sample(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL mul_dep: got %b want %b", obs, expv); end
      tick();
    end
  endtask

  task automatic test_kill();
    idle(6);
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL kill_load: got %b want %b", obs, expv); end
    tick();
    set_in(1, 4, 0, 1, 0, 1, 8, 0, 0, 1);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL kill_cycle: got %b want %b", obs, expv); end
    checks++;
    if ({hz.stall, hz.id_kill, hz.id_issue} !== 3'b010) begin
      errors++; $display("FAIL kill_wins: got %b want 010", {hz.stall, hz.id_kill, hz.id_issue});
    end
    tick();
    set_in(1, 8, 4, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); model_eval(); obs = sample(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL kill_after: got %b want %b", obs, expv); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    idle(6);
    set_in(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL b2b_second: got %b want %b", obs, expv); end
    tick();
    set_in(1, 10, 10, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL b2b_reader: got %b want %b", obs, expv); end
    checks++;
    if ({hz.fwd_a, hz.fwd_b} !== (FWD ? 4'b0101 : 4'b0000)) begin
      errors++; $display("FAIL b2b_youngest: got %b want %b", {hz.fwd_a, hz.fwd_b}, FWD ? 4'b0101 : 4'b0000);
    end
    for (int k = 0; k < 8 && hz.stall === 1'b1; k++) begin
      tick(); stalls++;
      @(negedge clk); model_eval(); obs = sample(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL b2b_wait: got %b want %b", obs, expv); end
    end
    checks++;
    if (stalls != (FWD ? 0 : 2)) begin
      errors++; $display("FAIL b2b_overwrite: got %0d stalls want %0d", stalls, FWD ? 0 : 2);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    idle(6);
    set_in(1, 0, 0, 0, 0, 1, 9, 0, 1, 0);
    tick();
    set_in(1, 9, 0, 1, 0, 1, 15, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL rst_pre: got %b want %b", obs, expv); end
    #1 clrn = 1'b0;
    #1;
    checks++;
    if ({hz.mul_busy, hz.stall, hz.id_issue} !== 3'b001) begin
      errors++; $display("FAIL rst_async: got busy/stall/issue=%b want 001", {hz.mul_busy, hz.stall, hz.id_issue});
    end
    model_reset();
    #1 clrn = 1'b1;
    tick();
    set_in(1, 15, 9, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); model_eval(); obs = sample(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL rst_post: got %b want %b", obs, expv); end
    tick();
  endtask

  task automatic test_random();
    idle(6);
    for (int n = 0; n < 400; n++) begin
      int c = $urandom_range(0, 19);
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
             $urandom_range(0, 7), c < 4, c >= 4 && c < 7, $urandom_range(0, 9) == 0);
      @(negedge clk); model_eval(); obs = sample(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL random[%0d]: got %b want %b", n, obs, expv); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_mul_occ();
    test_kill();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
